// File: rtl/attn_host_pkg.sv
// Shared types, beat counts and the 1/k! helper for the attention accelerator host.
// ATTN_HOST_DEBUG_OUT_EN selects whether DRAIN also streams the QK^T and exp matrices.
package attn_host_pkg;

  localparam int ATTN_N  = 4;
  localparam int ATTN_K  = 4;
  localparam int MATS_IN = 3;
  localparam int LOAD_BEATS = MATS_IN * ATTN_N;
`ifdef ATTN_HOST_DEBUG_OUT_EN
  localparam int MATS_OUT = 3;
`else
  localparam int MATS_OUT = 1;
`endif
  localparam int DRAIN_BEATS = MATS_OUT * ATTN_N;

  typedef real row_t [ATTN_N];
  typedef real mat_t [ATTN_N][ATTN_N];

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ACC_RST = 3'd2,
    WLOAD   = 3'd3,
    START   = 3'd4,
    WAIT    = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  function automatic real inv_factorial(input int unsigned k);
    real f;
    f = 1.0;
    for (int unsigned i = 2; i <= k; i++) f = f * real'(i);
    return 1.0 / f;
  endfunction

endpackage

// File: rtl/attn_mat_buf.sv
// N x N real matrix buffer: row write port, full-matrix parallel load, row read port, full-matrix view.
module attn_mat_buf #(
  parameter int N = 4,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  real           wrow [N],
  input  logic          load,
  input  real           lmat [N][N],
  input  logic [AW-1:0] raddr,
  output real           rrow [N],
  output real           mat  [N][N]
);

  real mem [N][N];

  // Parallel load takes priority; the host never asserts both in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++)
          mem[i][j] <= 0.0;
    end else if (load) begin
      mem <= lmat;
    end else if (we) begin
      mem[waddr] <= wrow;
    end
  end

  assign rrow = mem[raddr];
  assign mat  = mem;

endmodule

// File: rtl/attn_stream_host.sv
// Host-side stream driver for the systolic attention accelerator: loads Q/K/V rows, runs one job, drains results.
// ATTN_HOST_DEBUG_OUT_EN: when defined, DRAIN emits QK^T, exp and result rows (3N beats) instead of N result rows.
module attn_stream_host
  import attn_host_pkg::*;
#(
  parameter int N              = ATTN_N,
  parameter int K              = ATTN_K,
  parameter int WLOAD_WAIT     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  real  in_row [N],
  output logic out_valid,
  input  logic out_ready,
  output real  out_row [N],
  output logic out_last,
  output logic busy,
  output logic err,
  output logic acc_reset,
  output logic acc_valid_input,
  output real  acc_Q [N][N],
  output real  acc_K [N][N],
  output real  acc_V [N][N],
  output real  acc_factorial [K+1],
  input  real  acc_qk  [N][N],
  input  real  acc_exp [N][N],
  input  real  acc_res [N][N],
  input  logic acc_valid_result
);

  localparam int AW   = (N > 1) ? $clog2(N) : 1;
  localparam int TMAX = (TIMEOUT_CYCLES > WLOAD_WAIT) ? TIMEOUT_CYCLES : WLOAD_WAIT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [1:0] LAST_SEL = 2'(MATS_OUT - 1);

  state_t        state;
  logic [1:0]    sel;
  logic [AW-1:0] row;
  logic [TW-1:0] tmr;
  logic          accept;
  logic          capture;
  logic          row_end;

  real zero_row [N];
  real zero_mat [N][N];
  real q_rrow_unused [N];
  real k_rrow_unused [N];
  real v_rrow_unused [N];
  real res_rrow [N];
  real res_mat_unused [N][N];

  assign zero_row = '{default: 0.0};
  assign zero_mat = '{default: '{default: 0.0}};

  assign in_ready        = (state == LOAD);
  assign accept          = in_ready && in_valid;
  assign capture         = (state == WAIT) && acc_valid_result;
  assign row_end         = (row == AW'(N - 1));
  assign busy            = (state != IDLE);
  assign acc_reset       = reset || (state == ACC_RST);
  assign acc_valid_input = (state == START);
  assign out_valid       = (state == DRAIN);
  assign out_last        = out_valid && row_end && (sel == LAST_SEL);

  always_comb begin
    for (int unsigned k = 0; k <= K; k++) acc_factorial[k] = inv_factorial(k);
  end

  // sel/row count beats in LOAD (matrix, row) and are reused as the drain pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      row   <= '0;
      tmr   <= '0;
      err   <= 1'b0;
    end else begin
      if (accept) err <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          state <= LOAD;
          sel   <= '0;
          row   <= '0;
        end
        LOAD: if (in_valid) begin
          if (row_end) begin
            row <= '0;
            if (sel == 2'd2) begin
              state <= ACC_RST;
              sel   <= '0;
            end else begin
              sel <= sel + 2'd1;
            end
          end else begin
            row <= row + AW'(1);
          end
        end
        ACC_RST: begin
          state <= WLOAD;
          tmr   <= '0;
        end
        WLOAD: begin
          if (tmr == TW'(WLOAD_WAIT - 1)) state <= START;
          else                            tmr   <= tmr + TW'(1);
        end
        START: begin
          state <= WAIT;
          tmr   <= '0;
        end
        // A done pulse on the timeout cycle is checked first so it wins.
        WAIT: begin
          if (acc_valid_result) begin
            state <= DRAIN;
            sel   <= '0;
            row   <= '0;
          end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        DRAIN: if (out_ready) begin
          if (out_last) begin
            state <= IDLE;
          end else if (row_end) begin
            row <= '0;
            sel <= sel + 2'd1;
          end else begin
            row <= row + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  attn_mat_buf #(.N(N)) q_buf (
    .clk(clk), .reset(reset), .we(accept && (sel == 2'd0)), .waddr(row), .wrow(in_row),
    .load(1'b0), .lmat(zero_mat), .raddr('0), .rrow(q_rrow_unused), .mat(acc_Q)
  );

  attn_mat_buf #(.N(N)) k_buf (
    .clk(clk), .reset(reset), .we(accept && (sel == 2'd1)), .waddr(row), .wrow(in_row),
    .load(1'b0), .lmat(zero_mat), .raddr('0), .rrow(k_rrow_unused), .mat(acc_K)
  );

  attn_mat_buf #(.N(N)) v_buf (
    .clk(clk), .reset(reset), .we(accept && (sel == 2'd2)), .waddr(row), .wrow(in_row),
    .load(1'b0), .lmat(zero_mat), .raddr('0), .rrow(v_rrow_unused), .mat(acc_V)
  );

  attn_mat_buf #(.N(N)) res_buf (
    .clk(clk), .reset(reset), .we(1'b0), .waddr('0), .wrow(zero_row),
    .load(capture), .lmat(acc_res), .raddr(row), .rrow(res_rrow), .mat(res_mat_unused)
  );

`ifdef ATTN_HOST_DEBUG_OUT_EN
  real qk_rrow [N];
  real exp_rrow [N];
  real qk_mat_unused [N][N];
  real exp_mat_unused [N][N];

  attn_mat_buf #(.N(N)) qk_buf (
    .clk(clk), .reset(reset), .we(1'b0), .waddr('0), .wrow(zero_row),
    .load(capture), .lmat(acc_qk), .raddr(row), .rrow(qk_rrow), .mat(qk_mat_unused)
  );

  attn_mat_buf #(.N(N)) exp_buf (
    .clk(clk), .reset(reset), .we(1'b0), .waddr('0), .wrow(zero_row),
    .load(capture), .lmat(acc_exp), .raddr(row), .rrow(exp_rrow), .mat(exp_mat_unused)
  );

  always_comb begin
    case (sel)
      2'd0:    out_row = qk_rrow;
      2'd1:    out_row = exp_rrow;
      default: out_row = res_rrow;
    endcase
  end
`else
  real qk_in_unused  [N][N];
  real exp_in_unused [N][N];

  assign qk_in_unused  = acc_qk;
  assign exp_in_unused = acc_exp;
  assign out_row       = res_rrow;
`endif

endmodule

// File: tb/tb_attn_stream_host.sv
// Self-checking bench for attn_stream_host; plays the accelerator from a matrix-arithmetic reference model.
module tb_attn_stream_host;
  import attn_host_pkg::*;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int WW = 4;
  localparam int TO = 64;
  localparam real TOL = 1.0e-6;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_last, busy, err;
  logic acc_reset, acc_valid_input, acc_valid_result;
  real in_row [N];
  real out_row [N];
  real acc_Q [N][N];
  real acc_K [N][N];
  real acc_V [N][N];
  real acc_factorial [K+1];
  real acc_qk [N][N];
  real acc_exp [N][N];
  real acc_res [N][N];

  always #5 clk = ~clk;

  attn_stream_host #(.N(N), .K(K), .WLOAD_WAIT(WW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .busy(busy), .err(err), .acc_reset(acc_reset), .acc_valid_input(acc_valid_input),
    .acc_Q(acc_Q), .acc_K(acc_K), .acc_V(acc_V), .acc_factorial(acc_factorial),
    .acc_qk(acc_qk), .acc_exp(acc_exp), .acc_res(acc_res), .acc_valid_result(acc_valid_result)
  );

  int unsigned vecs = 0;
  int unsigned errs = 0;

  real sq [N][N];
  real sk [N][N];
  real sv [N][N];
  real mq [N][N];
  real me [N][N];
  real mres [N][N];
  real exp_rows [3*N][N];
  int unsigned n_exp;

  typedef struct { int unsigned k; real want; } fact_vec_t;
  typedef struct { int unsigned kind; logic [3:0] mask; int unsigned lat; } job_vec_t;

  task automatic chk_b(input string name, input logic act, input logic req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic chk_i(input string name, input int unsigned act, input int unsigned req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic chk_r(input string name, input real act, input real req);
    vecs++;
    if (act - req > TOL || req - act > TOL) begin
      errs++;
      $display("FAIL %s: got %f want %f", name, act, req);
    end
  endtask

  // Reference: QK^T, element-wise truncated Taylor exp, then exp * V.
  task automatic build_model(input int unsigned kind);
    real term, s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (kind == 0) begin
          sq[i][j] = (i == j) ? 1.0 : 0.0;
          sk[i][j] = sq[i][j];
          sv[i][j] = sq[i][j];
        end else begin
          sq[i][j] = real'($urandom_range(0, 8)) / 4.0 - 1.0;
          sk[i][j] = real'($urandom_range(0, 8)) / 4.0 - 1.0;
          sv[i][j] = real'($urandom_range(0, 8)) / 4.0 - 1.0;
        end
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mq[i][j] = 0.0;
        for (int x = 0; x < N; x++) mq[i][j] += sq[i][x] * sk[j][x];
        term = 1.0;
        s = 1.0;
        for (int t = 1; t <= K; t++) begin
          term = term * mq[i][j] / real'(t);
          s += term;
        end
        me[i][j] = s;
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mres[i][j] = 0.0;
        for (int x = 0; x < N; x++) mres[i][j] += me[i][x] * sv[x][j];
      end
    n_exp = 0;
`ifdef ATTN_HOST_DEBUG_OUT_EN
    for (int i = 0; i < N; i++) begin exp_rows[n_exp] = mq[i]; n_exp++; end
    for (int i = 0; i < N; i++) begin exp_rows[n_exp] = me[i]; n_exp++; end
`endif
    for (int i = 0; i < N; i++) begin exp_rows[n_exp] = mres[i]; n_exp++; end
  endtask

  task automatic send_beats(input int unsigned first, input int unsigned count);
    int unsigned guard;
    for (int unsigned b = first; b < first + count; b++) begin
      for (int j = 0; j < N; j++)
        in_row[j] = (b / N == 0) ? sq[b % N][j] : (b / N == 1) ? sk[b % N][j] : sv[b % N][j];
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
      if (!in_ready) begin
        chk_b("in_ready_timeout", in_ready, 1'b1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input logic [3:0] mask);
    int unsigned got, cyc;
    logic stalled, ok;
    real prev [N];
    got = 0; cyc = 0; stalled = 1'b0;
    while (got < n_exp && cyc < 200) begin
      if (stalled) begin
        ok = out_valid;
        for (int j = 0; j < N; j++) if (out_row[j] != prev[j]) ok = 1'b0;
        chk_b("stall_hold", ok, 1'b1);
      end
      out_ready = mask[cyc % 4];
      if (out_valid && out_ready) begin
        for (int j = 0; j < N; j++) chk_r($sformatf("beat%0d_col%0d", got, j), out_row[j], exp_rows[got][j]);
        chk_b($sformatf("last_beat%0d", got), out_last, (got == n_exp - 1) ? 1'b1 : 1'b0);
        got++;
      end
      stalled = out_valid && !out_ready;
      prev = out_row;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk_i("beat_count", got, n_exp);
    chk_b("drain_out_valid_low", out_valid, 1'b0);
    chk_b("drain_busy_low", busy, 1'b0);
  endtask

  task automatic run_tail(input logic [3:0] mask, input int unsigned lat);
    int unsigned gap;
    logic ok;
    chk_b("acc_reset_pulse", acc_reset, 1'b1);
    gap = 0;
    while (!acc_valid_input && gap < 50) begin @(negedge clk); gap++; end
    chk_i("start_gap", gap, WW + 1);
    ok = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (acc_Q[i][j] != sq[i][j] || acc_K[i][j] != sk[i][j] || acc_V[i][j] != sv[i][j]) ok = 1'b0;
    chk_b("acc_qkv_buffers", ok, 1'b1);
    acc_qk = mq; acc_exp = me; acc_res = mres;
    @(negedge clk);
    chk_b("valid_input_one_cycle", acc_valid_input, 1'b0);
    repeat (lat - 1) @(negedge clk);
    acc_valid_result = 1'b1;
    @(negedge clk);
    acc_valid_result = 1'b0;
    acc_qk = '{default: '{default: -99.0}};
    acc_exp = acc_qk;
    acc_res = acc_qk;
    collect(mask);
    chk_b("job_err_clear", err, 1'b0);
  endtask

  task automatic run_job(input int unsigned kind, input logic [3:0] mask, input int unsigned lat);
    build_model(kind);
    send_beats(0, 3 * N);
    run_tail(mask, lat);
  endtask

  fact_vec_t fact_tab [K+1];
  job_vec_t  job_tab [5];

  initial begin
    int unsigned cnt;
    fact_tab = '{'{0, 1.0}, '{1, 1.0}, '{2, 0.5}, '{3, 1.0/6.0}, '{4, 1.0/24.0}};
    job_tab = '{'{0, 4'b1111, 3}, '{0, 4'b1001, 3}, '{1, 4'b1111, 1},
                '{1, 4'b0101, 7}, '{1, 4'b1111, TO}};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_valid_result = 1'b0;
    in_row = '{default: 0.0};
    acc_qk = '{default: '{default: 0.0}};
    acc_exp = acc_qk;
    acc_res = acc_qk;
    repeat (3) @(negedge clk);
    chk_b("rst_acc_reset", acc_reset, 1'b1);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_in_ready", in_ready, 1'b0);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_out_last", out_last, 1'b0);
    chk_b("rst_err", err, 1'b0);
    chk_b("rst_valid_input", acc_valid_input, 1'b0);
    chk_r("rst_acc_Q", acc_Q[1][2], 0.0);
    reset = 1'b0;
    @(negedge clk);
    chk_b("post_rst_acc_reset", acc_reset, 1'b0);

    for (int unsigned i = 0; i <= K; i++)
      chk_r($sformatf("factorial%0d", fact_tab[i].k), acc_factorial[fact_tab[i].k], fact_tab[i].want);

    for (int i = 0; i < 5; i++) run_job(job_tab[i].kind, job_tab[i].mask, job_tab[i].lat);

    // Timeout: accelerator never answers.
    build_model(1);
    send_beats(0, 3 * N);
    cnt = 0;
    while (!acc_valid_input && cnt < 50) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (busy && cnt < 200) begin @(negedge clk); cnt++; end
    chk_i("timeout_cycles", cnt, TO + 1);
    chk_b("timeout_err", err, 1'b1);
    chk_b("timeout_in_ready", in_ready, 1'b0);
    chk_b("timeout_out_valid", out_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk_b("err_sticky", err, 1'b1);

    // IDLE->LOAD accepts no beat, so err survives until the first real beat.
    in_row = sq[0];
    in_valid = 1'b1;
    @(negedge clk);
    chk_b("load_entry_in_ready", in_ready, 1'b1);
    chk_b("load_entry_err_held", err, 1'b1);
    @(negedge clk);
    chk_b("err_cleared_by_beat", err, 1'b0);
    send_beats(1, 6);

    // Reset after 7 beats.
    reset = 1'b1;
    @(negedge clk);
    chk_b("midrst_busy", busy, 1'b0);
    chk_b("midrst_in_ready", in_ready, 1'b0);
    chk_b("midrst_acc_reset", acc_reset, 1'b1);
    chk_r("midrst_q_cleared", acc_Q[0][0], 0.0);
    reset = 1'b0;
    @(negedge clk);
    chk_b("midrst_released", acc_reset, 1'b0);
    run_job(1, 4'b1111, 3);

    // Done pulse while loading is ignored.
    build_model(1);
    send_beats(0, 5);
    acc_res = '{default: '{default: 7.0}};
    acc_valid_result = 1'b1;
    @(negedge clk);
    acc_valid_result = 1'b0;
    chk_b("stray_done_out_valid", out_valid, 1'b0);
    chk_b("stray_done_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk_b("stray_done_out_valid2", out_valid, 1'b0);
    send_beats(5, 3 * N - 5);
    run_tail(4'b1111, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
